// File: rtl/piano_pkg.sv
// ---------------------------------------------------------------------------
// piano_pkg
//   Shared definitions for the Digital Piano tone path.
//   - tone_state_t : FSM states of keypad_tone_player
//   - FREQ_CHZ     : chromatic octave C4..D#5 in centi-Hz, indexed by key code
//   - half_period  : square-wave half period in clock cycles for one key
//   - half_table   : all 16 half periods, packed, for elaboration-time tables
// ---------------------------------------------------------------------------
package piano_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        PLAY    = 3'd2,
        REL     = 3'd3,
        SUSTAIN = 3'd4
    } tone_state_t;

    localparam int PHASE_W   = 18;  // holds CLK_HZ/52326 at 100 MHz
    localparam int SUS_CNT_W = 25;

    localparam int unsigned FREQ_CHZ [16] = '{
        26163, 27718, 29366, 31113, 32963, 34923, 36999, 39200,
        41530, 44000, 46616, 49388, 52325, 55437, 58733, 62225
    };

    // Half period = clk_hz / (2 * f) with f in centi-Hz -> clk_hz*50 / f_chz.
    // 64-bit intermediate: clk_hz*50 exceeds 32 bits at 100 MHz.
    function automatic logic [PHASE_W-1:0] half_period(input longint unsigned clk_hz,
                                                       input logic [3:0]      code);
        longint unsigned h;
        h = (clk_hz * 64'd50) / longint'(FREQ_CHZ[code]);
        return h[PHASE_W-1:0];
    endfunction

    function automatic logic [15:0][PHASE_W-1:0] half_table(input longint unsigned clk_hz);
        logic [15:0][PHASE_W-1:0] t;
        for (int k = 0; k < 16; k++) begin
            t[k] = half_period(clk_hz, 4'(k));
        end
        return t;
    endfunction

endpackage

// File: rtl/square_wave_gen.sv
// ---------------------------------------------------------------------------
// square_wave_gen
//   50%-duty square wave: phase counter plus output toggle.
//   Ports:
//     clk, reset   : rising-edge clock, asynchronous active-high reset
//     enable       : count this cycle; low clears phase and forces wave low
//     restart      : clear phase and wave (start of a new note)
//     half_period  : cycles per half wave; first toggle comes half_period
//                    cycles after a restart
//     wave         : square-wave output (registered)
// ---------------------------------------------------------------------------
module square_wave_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        restart,
    input  logic [17:0] half_period,
    output logic        wave
);

    logic [17:0] phase_q, phase_d;
    logic        wave_q,  wave_d;

    always_comb begin
        phase_d = phase_q;
        wave_d  = wave_q;
        if (!enable || restart) begin
            phase_d = '0;
            wave_d  = 1'b0;
        end else if (phase_q == 18'(half_period - 18'd1)) begin
            phase_d = '0;
            wave_d  = ~wave_q;
        end else begin
            phase_d = 18'(phase_q + 18'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            wave_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            wave_q  <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/keypad_tone_player.sv
// ---------------------------------------------------------------------------
// keypad_tone_player
//   Debounces the keypad scanner output and plays the selected key of the
//   chromatic octave C4..D#5 as a square wave on the speaker pin.
//   Ports:
//     clk, reset   : rising-edge clock, asynchronous active-high reset
//     key_code     : scanner hex code, valid while key_pressed=1
//     key_pressed  : scanner flag, exactly one key detected
//     speaker      : square-wave audio output
//     note_on      : high while a tone is sounding
//     note_code    : code of the sounding or last sounded note
//   Build option:
//     TONE_SUSTAIN_EN : adds a SUSTAIN state that keeps the tone for
//                       SUSTAIN_CYCLES after a confirmed release.
// ---------------------------------------------------------------------------
module keypad_tone_player
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SUSTAIN_CYCLES  = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_pressed,
    output logic       speaker,
    output logic       note_on,
    output logic [3:0] note_code
);

    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0][PHASE_W-1:0] HALF_TBL = half_table(longint'(CLK_HZ));

    // Registered scanner inputs; every decision below uses these.
    logic [3:0]       key_q, key_d;
    logic             pressed_q, pressed_d;

    tone_state_t      state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       note_code_q, note_code_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             note_on_q, note_on_d;
    logic             restart;
    logic             active_d;
    logic             key_hit;
    logic             cand_hit;

`ifdef TONE_SUSTAIN_EN
    localparam logic [SUS_CNT_W-1:0] SUS_LAST = SUS_CNT_W'(SUSTAIN_CYCLES - 1);
    logic [SUS_CNT_W-1:0] sus_cnt_q, sus_cnt_d;
    // ARM entered from SUSTAIN: the old note keeps sounding while the new
    // key is being debounced.
    logic                 sus_arm_q, sus_arm_d;
`endif

    assign key_hit  = pressed_q && (key_q == note_code_q);
    assign cand_hit = pressed_q && (key_q == cand_q);

    always_comb begin
        key_d       = key_code;
        pressed_d   = key_pressed;
        state_d     = state_q;
        cand_d      = cand_q;
        note_code_d = note_code_q;
        deb_cnt_d   = deb_cnt_q;
        restart     = 1'b0;
`ifdef TONE_SUSTAIN_EN
        sus_cnt_d   = sus_cnt_q;
        sus_arm_d   = sus_arm_q;
`endif
        case (state_q)
            IDLE: begin
                if (pressed_q) begin
                    cand_d    = key_q;
                    deb_cnt_d = '0;
                    state_d   = ARM;
                end
            end
            ARM: begin
                if (!cand_hit) begin
                    state_d = IDLE;
`ifdef TONE_SUSTAIN_EN
                    sus_arm_d = 1'b0;
`endif
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = PLAY;
                    note_code_d = cand_q;
                    restart     = 1'b1;
`ifdef TONE_SUSTAIN_EN
                    sus_arm_d = 1'b0;
`endif
                end else begin
                    deb_cnt_d = DEB_W'(deb_cnt_q + DEB_W'(1));
                end
            end
            PLAY: begin
                if (!key_hit) begin
                    deb_cnt_d = '0;
                    state_d   = REL;
                end
            end
            REL: begin
                if (key_hit) begin
                    // Release glitch: resume without touching the phase.
                    state_d = PLAY;
                end else if (deb_cnt_q == DEB_LAST) begin
                    if (pressed_q) begin
                        // The new key was held through the whole release
                        // window; deb_cnt stays at its last value so ARM only
                        // needs one more matching cycle.
                        cand_d  = key_q;
                        state_d = ARM;
                    end else begin
`ifdef TONE_SUSTAIN_EN
                        sus_cnt_d = '0;
                        state_d   = SUSTAIN;
`else
                        state_d   = IDLE;
`endif
                    end
                end else begin
                    deb_cnt_d = DEB_W'(deb_cnt_q + DEB_W'(1));
                end
            end
`ifdef TONE_SUSTAIN_EN
            SUSTAIN: begin
                if (pressed_q) begin
                    cand_d    = key_q;
                    deb_cnt_d = '0;
                    sus_arm_d = 1'b1;
                    state_d   = ARM;
                end else if (sus_cnt_q == SUS_LAST) begin
                    state_d = IDLE;
                end else begin
                    sus_cnt_d = SUS_CNT_W'(sus_cnt_q + SUS_CNT_W'(1));
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Tone is live in the next cycle; leaving a tone state clears the
        // wave generator on the same edge.
`ifdef TONE_SUSTAIN_EN
        active_d = (state_d == PLAY) || (state_d == REL) || (state_d == SUSTAIN) ||
                   ((state_d == ARM) && sus_arm_d);
`else
        active_d = (state_d == PLAY) || (state_d == REL);
`endif
        note_on_d = active_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q       <= '0;
            pressed_q   <= 1'b0;
            state_q     <= IDLE;
            cand_q      <= '0;
            note_code_q <= '0;
            deb_cnt_q   <= '0;
            note_on_q   <= 1'b0;
`ifdef TONE_SUSTAIN_EN
            sus_cnt_q   <= '0;
            sus_arm_q   <= 1'b0;
`endif
        end else begin
            key_q       <= key_d;
            pressed_q   <= pressed_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            note_code_q <= note_code_d;
            deb_cnt_q   <= deb_cnt_d;
            note_on_q   <= note_on_d;
`ifdef TONE_SUSTAIN_EN
            sus_cnt_q   <= sus_cnt_d;
            sus_arm_q   <= sus_arm_d;
`endif
        end
    end

    // note_code_q only changes on ARM->PLAY, which also restarts the
    // generator, so the half period never changes mid-wave.
    square_wave_gen u_wave (
        .clk         (clk),
        .reset       (reset),
        .enable      (active_d),
        .restart     (restart),
        .half_period (HALF_TBL[note_code_q]),
        .wave        (speaker)
    );

    assign note_on   = note_on_q;
    assign note_code = note_code_q;

endmodule

// File: tb/tb_keypad_tone_player.sv
module tb_keypad_tone_player;

    localparam int CLK_HZ = 1_000_000;
    localparam int DEB    = 4;
    localparam int SUS    = 50;
`ifdef TONE_SUSTAIN_EN
    localparam int TAIL   = SUS;
`else
    localparam int TAIL   = 0;
`endif
    localparam int BIG    = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_code = 4'd0;
    logic       key_pressed = 1'b0;
    logic       speaker;
    logic       note_on;
    logic [3:0] note_code;

    keypad_tone_player #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DEB),
        .SUSTAIN_CYCLES  (SUS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .speaker     (speaker),
        .note_on     (note_on),
        .note_code   (note_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a list of tone segments, each an inclusive range of
    // clock edges during which one note sounds, starting at phase 0.
    int         seg_start [$];
    int         seg_end   [$];
    logic [3:0] seg_code  [$];

    function automatic int bhalf(input logic [3:0] k);
        int f [16];
        f = '{26163, 27718, 29366, 31113, 32963, 34923, 36999, 39200,
              41530, 44000, 46616, 49388, 52325, 55437, 58733, 62225};
        return (CLK_HZ * 50) / f[k];
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_model();
        logic       on;
        logic       spk;
        logic [3:0] code;
        on = 1'b0; spk = 1'b0; code = 4'd0;
        foreach (seg_start[i]) begin
            if (seg_start[i] <= cyc) begin
                code = seg_code[i];
                if (cyc <= seg_end[i]) begin
                    on  = 1'b1;
                    spk = 1'(((cyc - seg_start[i]) / bhalf(seg_code[i])) % 2);
                end
            end
        end
        chk("note_on",   {3'b0, note_on}, {3'b0, on});
        chk("speaker",   {3'b0, speaker}, {3'b0, spk});
        chk("note_code", note_code,       code);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            #1;
            check_model();
        end
    endtask

    task automatic open_seg(input int s, input logic [3:0] k);
        seg_start.push_back(s);
        seg_end.push_back(BIG);
        seg_code.push_back(k);
    endtask

    task automatic close_seg(input int e);
        seg_end[seg_end.size() - 1] = e;
    endtask

    // Releases the key; the first DUT edge that sees the release is cyc+1.
    task automatic release_key(input bit tone);
        if (tone) close_seg(cyc + 1 + DEB + TAIL);
        key_pressed = 1'b0;
        key_code    = 4'($urandom);
        step(DEB + 5 + TAIL);
    endtask

    task automatic press(input logic [3:0] k, input int len);
        if (len > DEB) open_seg(cyc + 1 + DEB + 1, k);
        key_pressed = 1'b1;
        key_code    = k;
        step(len);
        release_key(len > DEB);
    endtask

    // Mid-tone interruption of g <= DEB cycles: either a dropout or a
    // different key. Neither may disturb the running note.
    task automatic glitch(input logic [3:0] k, input int l1, input int g, input bit alt,
                          input int l2);
        open_seg(cyc + 1 + DEB + 1, k);
        key_pressed = 1'b1;
        key_code    = k;
        step(l1);
        if (alt) key_code = 4'(k + 4'd1 + 4'($urandom_range(13)));
        else     key_pressed = 1'b0;
        step(g);
        key_pressed = 1'b1;
        key_code    = k;
        step(l2);
        release_key(1'b1);
    endtask

    // Direct switch k1 -> k2: release window, one silent ARM cycle, new note.
    task automatic change(input logic [3:0] k1, input logic [3:0] k2, input int l1,
                          input int l2);
        int c;
        open_seg(cyc + 1 + DEB + 1, k1);
        key_pressed = 1'b1;
        key_code    = k1;
        step(l1);
        c = cyc + 1;
        close_seg(c + DEB);
        open_seg(c + DEB + 2, k2);
        key_code = k2;
        step(l2);
        release_key(1'b1);
    endtask

    task automatic reset_mid_tone(input logic [3:0] k);
        bit seen;
        int lim;
        seen = 1'b0;
        lim  = DEB + 4 + 2 * bhalf(k);
        open_seg(cyc + 1 + DEB + 1, k);
        key_pressed = 1'b1;
        key_code    = k;
        for (int i = 0; i < lim && !seen; i++) begin
            step(1);
            if (speaker === 1'b1) seen = 1'b1;
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL spk_wait cyc=%0d got=%0b exp=1", cyc, seen);
        end
        #2 reset = 1'b1;
        #1;
        chk("rst_speaker",   {3'b0, speaker}, 4'd0);
        chk("rst_note_on",   {3'b0, note_on}, 4'd0);
        chk("rst_note_code", note_code,       4'd0);
        seg_start.delete();
        seg_end.delete();
        seg_code.delete();
        key_pressed = 1'b0;
        step(2);
        reset = 1'b0;
        step(DEB + 5);
    endtask

    initial begin
        logic [3:0] k, k2;
        #1;
        chk("reset_note_on",   {3'b0, note_on}, 4'd0);
        chk("reset_speaker",   {3'b0, speaker}, 4'd0);
        chk("reset_note_code", note_code,       4'd0);
        step(3);
        reset = 1'b0;
        step(3);

        // Directed cases from the plan.
        press(4'd9, 3000);
        press(4'd3, 2);
        glitch(4'd0, 1500, 2, 1'b0, 1500);
        change(4'd5, 4'd12, 1200, 2500);

        // Boundaries: longest rejected press, shortest accepted press,
        // longest rejected glitch.
        press(4'($urandom), DEB);
        press(4'($urandom), DEB + 1);
        glitch(4'($urandom), 800, DEB, 1'b0, 800);

        // Randomized mix.
        for (int i = 0; i < 3; i++) begin
            press(4'($urandom), $urandom_range(500, 3000));
            press(4'($urandom), $urandom_range(1, DEB));
            k = 4'($urandom);
            glitch(k, $urandom_range(DEB + 2, 1500), $urandom_range(1, DEB),
                   1'($urandom), $urandom_range(10, 1500));
            k  = 4'($urandom);
            k2 = 4'(k + 4'd1 + 4'($urandom_range(14)));
            change(k, k2, $urandom_range(DEB + 1, 2000), $urandom_range(DEB + 2, 2000));
        end

        reset_mid_tone(4'($urandom_range(1, 15)));
        press(4'($urandom), $urandom_range(500, 1500));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
